// File: rtl/seq_restoring_divider_if.sv
// Start/done bundle for seq_restoring_divider. The state field exposes the
// divider FSM encoding for debug and checker binding.
interface seq_restoring_divider_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic [1:0]       state;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, state
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, state
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider, one quotient bit per clock, WIDTH iterations.
// Optional macro SEQ_DIVIDER_SIGNED_EN selects two's-complement operands.
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input logic                    clk,
  input logic                    rst,
  seq_restoring_divider_if.slave bus
);
  // Handshake: start is sampled only while busy=0; the accepting edge captures
  // dividend/divisor. done is a one-cycle pulse with results valid, and the
  // results hold until the next done. start while busy is dropped, not queued.

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   p;
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] fix_q;
  logic [WIDTH-1:0] fix_r;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] rem_r;
  logic             dbz_r;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             neg_q;
  logic             neg_r;
`endif

  // The restored remainder is always below the divisor, so WIDTH bits hold it;
  // only the shifted/trial value needs the extra bit.
  always_comb begin
    p      = {r, q[WIDTH-1]};
    t      = p - {1'b0, dvs};
    q_next = {q[WIDTH-2:0], ~t[WIDTH]};
    r_next = t[WIDTH] ? p[WIDTH-1:0] : t[WIDTH-1:0];
  end

`ifdef SEQ_DIVIDER_SIGNED_EN
  always_comb begin
    a_mag = bus.dividend[WIDTH-1] ? (~bus.dividend + 1'b1) : bus.dividend;
    b_mag = bus.divisor[WIDTH-1]  ? (~bus.divisor + 1'b1)  : bus.divisor;
    fix_q = neg_q ? (~q_next + 1'b1) : q_next;
    fix_r = neg_r ? (~r_next + 1'b1) : r_next;
  end
`else
  always_comb begin
    a_mag = bus.dividend;
    b_mag = bus.divisor;
    fix_q = q_next;
    fix_r = r_next;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      r      <= '0;
      q      <= '0;
      dvs    <= '0;
      cnt    <= '0;
      quot_r <= '0;
      rem_r  <= '0;
      dbz_r  <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            cnt   <= '0;
            r     <= '0;
            q     <= a_mag;
            dvs   <= b_mag;
            dbz_r <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            neg_r <= bus.dividend[WIDTH-1];
`endif
            if (bus.divisor == '0) begin
              state  <= S_DONE;
              dbz_r  <= 1'b1;
              quot_r <= '1;
              rem_r  <= bus.dividend;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r   <= r_next;
          q   <= q_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state  <= S_DONE;
            quot_r <= fix_q;
            rem_r  <= fix_r;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = (state == S_DONE);
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.state       = state;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed corner cases plus
// random operand pairs against an arithmetic reference model.
module tb_seq_restoring_divider;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_restoring_divider_if #(.WIDTH(W)) dif ();

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [2*W:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {div_by_zero, quotient, remainder} from plain arithmetic.
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] qv;
    logic [W-1:0] rv;
`ifdef SEQ_DIVIDER_SIGNED_EN
    int sa;
    int sb;
`endif
    if (b == '0) begin
      qv = '1;
      rv = a;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
      qv = W'(sa / sb);
      rv = W'(sa % sb);
`else
      qv = a / b;
      rv = a % b;
`endif
    end
    return {(b == '0), qv, rv};
  endfunction

  task automatic check_results(input string tag);
    logic [2*W:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected_done"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_quotient"}, dif.quotient, e[2*W-1:W]);
    check({tag, "_remainder"}, dif.remainder, e[W-1:0]);
    check({tag, "_dbz"}, dif.div_by_zero, e[2*W]);
    @(negedge clk);
    check({tag, "_done_pulse"}, dif.done, 0);
    check({tag, "_idle"}, dif.busy, 0);
    check({tag, "_hold_q"}, dif.quotient, e[2*W-1:W]);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc;
    @(negedge clk);
    dif.start    = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    exp_q.push_back(model(a, b));
    @(negedge clk);
    dif.start    = 1'b0;
    dif.dividend = W'($urandom);
    dif.divisor  = W'($urandom);
    cyc = 1;
    check({tag, "_busy"}, dif.busy, 1);
    while (!dif.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, (b == '0) ? 1 : W + 1);
    check_results(tag);
  endtask

  initial begin
    int cyc;
    int n_done;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", dif.busy, 0);
    check("rst_done", dif.done, 0);
    check("rst_quotient", dif.quotient, 0);
    check("rst_remainder", dif.remainder, 0);
    check("rst_dbz", dif.div_by_zero, 0);
    rst = 1'b0;

    run_op("d15_4", 4'd15, 4'd4);
    run_op("d7_15", 4'd7, 4'd15);
    run_op("d15_1", 4'd15, 4'd1);
    run_op("d9_0", 4'd9, 4'd0);
    run_op("d8_2", 4'd8, 4'd2);
    run_op("d9_2", 4'b1001, 4'd2);
    run_op("d8_15", 4'b1000, 4'b1111);
    run_op("d0_0", 4'd0, 4'd0);
    run_op("d0_5", 4'd0, 4'd5);

    // start pulsed again two cycles into an operation must be dropped
    @(negedge clk);
    dif.start    = 1'b1;
    dif.dividend = 4'd15;
    dif.divisor  = 4'd4;
    exp_q.push_back(model(4'd15, 4'd4));
    @(negedge clk);
    dif.start = 1'b0;
    cyc = 1;
    while (!dif.done && cyc < 40) begin
      if (cyc == 2) begin
        dif.start    = 1'b1;
        dif.dividend = 4'd6;
        dif.divisor  = 4'd3;
      end else begin
        dif.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    dif.start = 1'b0;
    check("ign_latency", cyc, W + 1);
    check_results("ign");
    n_done = 0;
    repeat (2 * W) begin
      @(negedge clk);
      if (dif.done) n_done++;
    end
    check("ign_no_second_done", n_done, 0);

    // reset on the third RUN cycle abandons the operation
    @(negedge clk);
    dif.start    = 1'b1;
    dif.dividend = 4'd15;
    dif.divisor  = 4'd4;
    @(negedge clk);
    dif.start = 1'b0;
    n_done = 0;
    for (int i = 1; i < 3; i++) begin
      if (dif.done) n_done++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", dif.busy, 0);
    check("mid_rst_done", dif.done, 0);
    check("mid_rst_quotient", dif.quotient, 0);
    check("mid_rst_remainder", dif.remainder, 0);
    check("mid_rst_dbz", dif.div_by_zero, 0);
    repeat (W + 2) begin
      @(negedge clk);
      if (dif.done) n_done++;
    end
    check("mid_rst_no_done", n_done, 0);
    exp_q.delete();
    run_op("d12_5", 4'd12, 4'd5);

    for (int i = 0; i < 40; i++) begin
      run_op("rand", W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Sequential restoring divider: the inverse direction of the team's shift-add arithmetic built on the 5-bit add stage.
- Reuses the same WIDTH+1-bit partial-remainder datapath, but subtracts the divisor and restores instead of adding.
- Accepts one dividend/divisor pair per start pulse and produces quotient and remainder after WIDTH iteration cycles.
- Sits beside the multiplier in the arithmetic unit, controlled by a simple start/done handshake.

Parameters:
- WIDTH, 4, operand width; the partial remainder is WIDTH+1 bits; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  numerator; captured on the accepting edge.
- divisor  input  WIDTH  denominator; captured on the accepting edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  WIDTH  registered result.
- remainder  output  WIDTH  registered result.
- div_by_zero  output  1  set with done when divisor==0; held until the next accepted start.

Behaviour:
- Reset: rst high at a rising edge forces state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
- rst wins over every other input, including mid-RUN: the operation is abandoned and no done is produced.
- Clock and reset naming: single clock clk; reset rst is synchronous and active-high.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge captures the operands, clears div_by_zero, counter=0.
  - Next state is RUN, or DONE directly if divisor==0.
  - start=0 leaves the state in IDLE.
- RUN, one iteration per edge:
  - P = {R[WIDTH-1:0], Q[WIDTH-1]}, where R is the (WIDTH+1)-bit partial remainder and Q is the dividend/quotient shift register.
  - T = P - {1'b0, divisor}, computed in WIDTH+1 bits.
  - If T[WIDTH]=0: R=T and Q={Q[WIDTH-2:0],1}.
  - Otherwise: R=P (restore) and Q={Q[WIDTH-2:0],0}.
  - Counter increments; after the WIDTH-th iteration the next state is DONE.
- DONE:
  - quotient and remainder registers load on the edge entering DONE; done=1 for exactly this one cycle.
  - Next edge returns to IDLE unconditionally.
- Latency: done is high during the cycle after the WIDTH+1-th rising edge counted from the edge that accepted start (WIDTH=4: cycle after edge 5, edge 1 being the accept edge).
- Divide-by-zero: done is high during the cycle after the accept edge (edge 1). Results: quotient=all ones, remainder=dividend, div_by_zero=1.
- start while busy (RUN or DONE) is ignored; operands are not recaptured; there is no queueing.
- Back-to-back: start is accepted again only in IDLE, so the minimum issue interval is WIDTH+2 cycles.
- quotient, remainder and div_by_zero hold their values between done pulses.
- Results hold the true unsigned quotient/remainder for all inputs; dividend < divisor gives quotient=0, remainder=dividend.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined:
  - Operands are two's complement. Magnitudes are taken on capture and the unsigned core runs unchanged.
  - Quotient is negated if the operand signs differ (truncation toward zero).
  - Remainder takes the dividend's sign.
  - Overflow case (most-negative / -1): quotient=most-negative, remainder=0, no flag.
  - Sign fix-up is applied on the edge entering DONE, so latency is unchanged.
  - Divide-by-zero: quotient=all ones (-1), remainder=dividend.
- Undefined: purely unsigned behaviour as above; no sign logic synthesized.

Test Plan:
- WIDTH=4, dividend=15, divisor=4, start pulsed 1 cycle -> done high only in the cycle after edge 5; quotient=3, remainder=3, div_by_zero=0; busy high in between.
- dividend=7, divisor=15 -> quotient=0, remainder=7; dividend=15, divisor=1 -> quotient=15, remainder=0.
- dividend=9, divisor=0 -> done in the cycle after edge 1; quotient=4'b1111, remainder=9, div_by_zero=1. A following valid op (8/2) clears the flag: quotient=4, remainder=0.
- start re-asserted with 6/3 two cycles into a 15/4 operation -> ignored; result is still 3 rem 3; no second done until a start is sampled in IDLE.
- rst pulsed on the third RUN cycle -> all outputs 0 next cycle, no done pulse; a new 12/5 op completes with quotient=2, remainder=2.
- SEQ_DIVIDER_SIGNED_EN, dividend=-7 (4'b1001), divisor=2 -> quotient=-3 (4'b1101), remainder=-1 (4'b1111); -8/-1 -> quotient=4'b1000, remainder=0.
